in_cell: RTL

IN_CELL -- requirements
Module: in_cell

---
 rtl/in_cell.sv | 118 +++++++++++
 1 files changed

// File: rtl/in_cell.sv
// Input cell: pad buffer plus an optional synchronized, glitch-filtered,
// edge-detecting registered path. IN_BUFF is a pure pass-through; IN_REG
// adds a synchronizer chain, a persistence filter and rise/fall pulses.
module in_cell #(
    parameter string MODE        = "IN_REG",
    parameter int    SYNC_STAGES = 2,
    parameter int    FILTER_LEN  = 0,
    parameter logic  INIT        = 1'b0
) (
    input  logic IQC,
    input  logic QRT,
    input  logic IQE,
    input  logic IPAD,
    output logic IZ,
    output logic IQZ,
    output logic IQR,
    output logic IQF
);

    // Parameter legality is enforced at elaboration so a bad configuration
    // never reaches silicon.
    if ((SYNC_STAGES < 1) || (SYNC_STAGES > 3)) begin : g_bad_sync
        $error("in_cell: SYNC_STAGES must be in 1..3");
    end
    if ((FILTER_LEN < 0) || (FILTER_LEN > 15)) begin : g_bad_filter
        $error("in_cell: FILTER_LEN must be in 0..15");
    end

    // The unregistered tap is always a straight wire from the pad.
    assign IZ = IPAD;

    if (MODE == "IN_REG") begin : g_reg
        localparam logic [3:0] FL = 4'(FILTER_LEN);

        logic [SYNC_STAGES-1:0] r_sync;
        logic [3:0]             r_cnt;
        logic                   r_iqz;
        logic                   r_iqr;
        logic                   r_iqf;

        logic       w_s;
        logic [3:0] w_cnt_nxt;
        logic       w_iqz_nxt;
        logic       w_rise;
        logic       w_fall;

        assign w_s = r_sync[SYNC_STAGES-1];

        // Synchronizer chain: shifts every cycle regardless of IQE.
        always_ff @(posedge IQC) begin
            if (QRT) begin
                r_sync <= {SYNC_STAGES{INIT}};
            end else begin
                r_sync[0] <= IPAD;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end

        // Filter decision: a level must be seen on FILTER_LEN+1 enabled
        // cycles in a row before it is accepted; any return to the current
        // output level restarts the count, and IQE low freezes it.
        always_comb begin
            w_cnt_nxt = r_cnt;
            w_iqz_nxt = r_iqz;
            w_rise    = 1'b0;
            w_fall    = 1'b0;
            if (w_s == r_iqz) begin
                w_cnt_nxt = 4'd0;
            end else if (IQE) begin
                if (r_cnt == FL) begin
                    w_iqz_nxt = w_s;
                    w_cnt_nxt = 4'd0;
                    w_rise    = w_s;
                    w_fall    = ~w_s;
                end else begin
                    w_cnt_nxt = 4'(r_cnt + 4'd1);
                end
            end else begin
                w_cnt_nxt = r_cnt;
                w_iqz_nxt = r_iqz;
            end
        end

        // Output register, filter counter and one-cycle edge pulses.
        always_ff @(posedge IQC) begin
            if (QRT) begin
                r_cnt <= 4'd0;
                r_iqz <= INIT;
                r_iqr <= 1'b0;
                r_iqf <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_iqz <= w_iqz_nxt;
                r_iqr <= w_rise;
                r_iqf <= w_fall;
            end
        end

        assign IQZ = r_iqz;
        assign IQR = r_iqr;
        assign IQF = r_iqf;
    end else if (MODE == "IN_BUFF") begin : g_buff
        // Pure buffer: no state, clock/reset/enable intentionally unused.
        logic w_unused_buff;
        assign w_unused_buff = ^{IQC, QRT, IQE};
        assign IQZ = IPAD;
        assign IQR = 1'b0;
        assign IQF = 1'b0;
    end else begin : g_bad_mode
        $error("in_cell: MODE must be IN_REG or IN_BUFF");
        assign IQZ = 1'b0;
        assign IQR = 1'b0;
        assign IQF = 1'b0;
    end

endmodule
